// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between a 1-byte register-file
// read source and a 2-byte ALU result source. Each source has a one-entry
// holding slot. Full slots are granted round-robin, and every frame byte goes
// through the TX parallel-load handshake with a busy-rise timeout.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64,
    parameter int TO_WIDTH   = 7
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RD_DATA,
    input  logic                      RD_VALID,
    output logic                      RD_READY,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_VALID,
    output logic                      ALU_READY,
    input  logic                      TX_BUSY,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VALID,
    output logic                      OVF,
    output logic                      TO_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_e;

    localparam logic SRC_RD = 1'b0;

    state_e                    state_q, state_d;
    logic                      rdEmpty_q, rdEmpty_d;
    logic                      aluEmpty_q, aluEmpty_d;
    logic [DATA_WIDTH-1:0]     rdData_q, rdData_d;
    logic [2*DATA_WIDTH-1:0]   aluData_q, aluData_d;
    logic                      ptr_q, ptr_d;
    logic [2*DATA_WIDTH-1:0]   frame_q, frame_d;
    logic                      twoByte_q, twoByte_d;
    logic                      idx_q, idx_d;
    logic [TO_WIDTH-1:0]       cnt_q, cnt_d;
    logic                      txValid_q, txValid_d;
    logic [DATA_WIDTH-1:0]     txData_q, txData_d;
    logic                      ovf_q, ovf_d;
    logic                      toErr_q, toErr_d;
    logic                      grantRd, grantAlu;
    logic [DATA_WIDTH-1:0]     curByte;

    assign curByte = idx_q ? frame_q[2*DATA_WIDTH-1:DATA_WIDTH] : frame_q[DATA_WIDTH-1:0];

    // Holding slots: load on a strobe into an empty slot, drop (and flag overflow) otherwise, empty on grant
    always_comb begin
        rdEmpty_d  = rdEmpty_q;
        rdData_d   = rdData_q;
        aluEmpty_d = aluEmpty_q;
        aluData_d  = aluData_q;
        if (grantRd) begin
            rdEmpty_d = 1'b1;
        end
        if (grantAlu) begin
            aluEmpty_d = 1'b1;
        end
        if (RD_VALID && rdEmpty_q) begin
            rdEmpty_d = 1'b0;
            rdData_d  = RD_DATA;
        end
        if (ALU_VALID && aluEmpty_q) begin
            aluEmpty_d = 1'b0;
            aluData_d  = ALU_OUT;
        end
        ovf_d = (RD_VALID && !rdEmpty_q) || (ALU_VALID && !aluEmpty_q);
    end

    // Arbitration and per-byte load/drain sequencing; outputs are computed here and registered below
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        frame_d   = frame_q;
        twoByte_d = twoByte_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        txValid_d = 1'b0;
        txData_d  = txData_q;
        toErr_d   = 1'b0;
        grantRd   = 1'b0;
        grantAlu  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!TX_BUSY) begin
                    if (!rdEmpty_q && !aluEmpty_q) begin
                        if (ptr_q == SRC_RD) begin
                            grantRd = 1'b1;
                        end else begin
                            grantAlu = 1'b1;
                        end
                        ptr_d = ~ptr_q;
                    end else if (!rdEmpty_q) begin
                        grantRd = 1'b1;
                    end else if (!aluEmpty_q) begin
                        grantAlu = 1'b1;
                    end
                end
                if (grantRd) begin
                    frame_d   = {{DATA_WIDTH{1'b0}}, rdData_q};
                    twoByte_d = 1'b0;
                end
                if (grantAlu) begin
                    frame_d   = aluData_q;
                    twoByte_d = 1'b1;
                end
                if (grantRd || grantAlu) begin
                    idx_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (TX_BUSY) begin
                    state_d = DRAIN;
                end else if (cnt_q == TO_WIDTH'(TIMEOUT - 1)) begin
                    toErr_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    txValid_d = 1'b1;
                    txData_d  = curByte;
                    if (txValid_q) begin
                        cnt_d = cnt_q + TO_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (!TX_BUSY) begin
                    if (twoByte_q && !idx_q) begin
                        idx_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, slot and output registers; reset abandons any frame in progress
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            rdEmpty_q  <= 1'b1;
            aluEmpty_q <= 1'b1;
            rdData_q   <= '0;
            aluData_q  <= '0;
            ptr_q      <= SRC_RD;
            frame_q    <= '0;
            twoByte_q  <= 1'b0;
            idx_q      <= 1'b0;
            cnt_q      <= '0;
            txValid_q  <= 1'b0;
            txData_q   <= '0;
            ovf_q      <= 1'b0;
            toErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdEmpty_q  <= rdEmpty_d;
            aluEmpty_q <= aluEmpty_d;
            rdData_q   <= rdData_d;
            aluData_q  <= aluData_d;
            ptr_q      <= ptr_d;
            frame_q    <= frame_d;
            twoByte_q  <= twoByte_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            txValid_q  <= txValid_d;
            txData_q   <= txData_d;
            ovf_q      <= ovf_d;
            toErr_q    <= toErr_d;
        end
    end

    assign RD_READY   = rdEmpty_q;
    assign ALU_READY  = aluEmpty_q;
    assign TX_P_DATA  = txData_q;
    assign TX_D_VALID = txValid_q;
    assign OVF        = ovf_q;
    assign TO_ERR     = toErr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: drives the scheduler with directed request vectors
// against a small UART TX model that raises busy three cycles after a load
// request and holds it for twenty cycles, collecting the bytes it accepts.
module tb_uart_tx_scheduler;

    logic        CLK;
    logic        RST;
    logic [7:0]  rdData;
    logic        rdValid;
    logic        rdReady;
    logic [15:0] aluOut;
    logic        aluValid;
    logic        aluReady;
    logic        busyToDut;
    logic [7:0]  txPData;
    logic        txDValid;
    logic        ovf;
    logic        toErr;

    logic        modelBusy;
    logic        forceBusy;
    logic        modelEn;
    int          holdCnt;
    int          validCnt;
    int          violations;
    logic [7:0]  firstByte;
    logic [7:0]  sent[$];

    int          testsRun;
    int          testsFailed;

    typedef struct packed {
        logic        rdValid;
        logic [7:0]  rdData;
        logic        aluValid;
        logic [15:0] aluOut;
        logic [1:0]  expCount;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        logic [7:0]  exp2;
    } vec_t;

    vec_t vecs [4];

    assign busyToDut = modelBusy | forceBusy;

    uart_tx_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .RD_DATA   (rdData),
        .RD_VALID  (rdValid),
        .RD_READY  (rdReady),
        .ALU_OUT   (aluOut),
        .ALU_VALID (aluValid),
        .ALU_READY (aluReady),
        .TX_BUSY   (busyToDut),
        .TX_P_DATA (txPData),
        .TX_D_VALID(txDValid),
        .OVF       (ovf),
        .TO_ERR    (toErr)
    );

    // 10 ns system clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // UART TX model: accepts a byte after seeing the load request for three cycles, then stays busy twenty cycles
    initial begin
        modelBusy  = 1'b0;
        holdCnt    = 0;
        validCnt   = 0;
        violations = 0;
        firstByte  = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                modelBusy = 1'b0;
                holdCnt   = 0;
                validCnt  = 0;
            end else if (modelBusy) begin
                if (txDValid) begin
                    violations++;
                end
                holdCnt--;
                if (holdCnt == 0) begin
                    modelBusy = 1'b0;
                end
            end else if (txDValid && modelEn) begin
                validCnt++;
                if (validCnt == 1) begin
                    firstByte = txPData;
                end
                if (validCnt == 3) begin
                    if (txPData !== firstByte) begin
                        violations++;
                    end
                    sent.push_back(txPData);
                    modelBusy = 1'b1;
                    holdCnt   = 20;
                    validCnt  = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] alu);
        @(negedge CLK);
        rdValid  = rv;
        rdData   = rd;
        aluValid = av;
        aluOut   = alu;
        @(negedge CLK);
        rdValid  = 1'b0;
        aluValid = 1'b0;
    endtask

    task automatic waitFrame(input int n);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge CLK);
            if (sent.size() >= n && !txDValid && !modelBusy && rdReady && aluReady) begin
                done = 1'b1;
            end
        end
        checkOutput("frameDone", 32'(done), 32'd1);
        repeat (40) @(negedge CLK);
        checkOutput("busyHandshake", 32'(violations), 32'd0);
    endtask

    task automatic checkBytes(input string tag, input int n, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0]  expArr [3];
        logic [31:0] act;
        expArr[0] = e0;
        expArr[1] = e1;
        expArr[2] = e2;
        checkOutput($sformatf("%s_count", tag), 32'(sent.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
            act = (j < sent.size()) ? 32'(sent[j]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s_byte%0d", tag, j), act, 32'(expArr[j]));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput($sformatf("%s_txValid", tag), 32'(txDValid), 32'd0);
        checkOutput($sformatf("%s_txData", tag), 32'(txPData), 32'd0);
        checkOutput($sformatf("%s_rdReady", tag), 32'(rdReady), 32'd1);
        checkOutput($sformatf("%s_aluReady", tag), 32'(aluReady), 32'd1);
        checkOutput($sformatf("%s_ovf", tag), 32'(ovf), 32'd0);
        checkOutput($sformatf("%s_toErr", tag), 32'(toErr), 32'd0);
    endtask

    initial begin
        int  vcnt;
        bit  seen;
        bit  dataBad;
        bit  reached;

        testsRun    = 0;
        testsFailed = 0;
        RST         = 1'b1;
        rdValid     = 1'b0;
        rdData      = 8'h00;
        aluValid    = 1'b0;
        aluOut      = 16'h0000;
        forceBusy   = 1'b0;
        modelEn     = 1'b1;

        vecs[0] = '{1'b0, 8'h00, 1'b1, 16'h1234, 2'd2, 8'h34, 8'h12, 8'h00};
        vecs[1] = '{1'b1, 8'h11, 1'b1, 16'hBEEF, 2'd3, 8'h11, 8'hEF, 8'hBE};
        vecs[2] = '{1'b1, 8'h22, 1'b1, 16'hCAFE, 2'd3, 8'hFE, 8'hCA, 8'h22};
        vecs[3] = '{1'b1, 8'h33, 1'b1, 16'h0102, 2'd3, 8'h33, 8'h02, 8'h01};

        repeat (3) @(negedge CLK);
        checkResetValues("reset");
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single RD byte with cycle-exact latency and READY timing
        sent.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0, 16'h0000);
        checkOutput("lat_rdReadyLow", 32'(rdReady), 32'd0);
        checkOutput("lat_validN", 32'(txDValid), 32'd0);
        @(negedge CLK);
        checkOutput("lat_rdReadyBack", 32'(rdReady), 32'd1);
        checkOutput("lat_validN1", 32'(txDValid), 32'd0);
        @(negedge CLK);
        checkOutput("lat_validN2", 32'(txDValid), 32'd1);
        checkOutput("lat_dataN2", 32'(txPData), 32'hA5);
        waitFrame(1);
        checkBytes("singleRd", 1, 8'hA5, 8'h00, 8'h00);
        checkOutput("holdLastByte", 32'(txPData), 32'hA5);

        // Table-driven frames: ALU byte order and round-robin contention
        for (int i = 0; i < 4; i++) begin
            sent.delete();
            applyStimulus(vecs[i].rdValid, vecs[i].rdData, vecs[i].aluValid, vecs[i].aluOut);
            waitFrame(int'(vecs[i].expCount));
            checkBytes($sformatf("vec%0d", i), int'(vecs[i].expCount), vecs[i].exp0, vecs[i].exp1, vecs[i].exp2);
        end

        // Overflow while external busy blocks grants
        sent.delete();
        forceBusy = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 16'h0000);
        checkOutput("ovf_firstLoad", 32'(ovf), 32'd0);
        checkOutput("ovf_rdReadyLow", 32'(rdReady), 32'd0);
        applyStimulus(1'b1, 8'h88, 1'b0, 16'h0000);
        checkOutput("ovf_rdDrop", 32'(ovf), 32'd1);
        @(negedge CLK);
        checkOutput("ovf_pulseEnd", 32'(ovf), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h5566);
        checkOutput("ovf_aluLoad", 32'(ovf), 32'd0);
        checkOutput("ovf_aluReadyLow", 32'(aluReady), 32'd0);
        applyStimulus(1'b1, 8'h99, 1'b1, 16'hDEAD);
        checkOutput("ovf_bothDrop", 32'(ovf), 32'd1);
        @(negedge CLK);
        checkOutput("ovf_bothPulseEnd", 32'(ovf), 32'd0);
        checkOutput("ovf_noLoadWhileBusy", 32'(txDValid), 32'd0);
        forceBusy = 1'b0;
        waitFrame(3);
        checkBytes("ovf", 3, 8'h66, 8'h55, 8'h77);

        // Timeout with the transmitter never going busy
        sent.delete();
        modelEn = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0000);
        vcnt    = 0;
        seen    = 1'b0;
        dataBad = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge CLK);
            if (txDValid) begin
                vcnt++;
                if (txPData !== 8'h5A) begin
                    dataBad = 1'b1;
                end
            end
            if (toErr) begin
                seen = 1'b1;
            end
        end
        checkOutput("to_errSeen", 32'(seen), 32'd1);
        checkOutput("to_validCycles", 32'(vcnt), 32'd64);
        checkOutput("to_dataStable", 32'(dataBad), 32'd0);
        checkOutput("to_validDropped", 32'(txDValid), 32'd0);
        checkOutput("to_rdReady", 32'(rdReady), 32'd1);
        @(negedge CLK);
        checkOutput("to_pulseEnd", 32'(toErr), 32'd0);
        checkOutput("to_staysIdle", 32'(txDValid), 32'd0);
        modelEn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hA1B2);
        waitFrame(2);
        checkBytes("afterTo", 2, 8'hB2, 8'hA1, 8'h00);

        // Reset in the middle of an ALU frame, with both slots refilled
        sent.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hC3D4);
        reached = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            @(negedge CLK);
            if (sent.size() == 1 && modelBusy) begin
                reached = 1'b1;
            end
        end
        checkOutput("rst_reachedDrain", 32'(reached), 32'd1);
        repeat (2) @(negedge CLK);
        applyStimulus(1'b1, 8'h44, 1'b1, 16'h7788);
        checkOutput("rst_rdSlotFull", 32'(rdReady), 32'd0);
        checkOutput("rst_aluSlotFull", 32'(aluReady), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkResetValues("midReset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        checkOutput("rst_byte1NeverSent", 32'(sent.size()), 32'd1);
        checkOutput("rst_idleAfter", 32'(txDValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
